// File: rtl/lfsr_add_bist.sv
// lfsr_add_bist: self-running adder BIST. Two seeded Galois LFSRs feed a
// WIDTH-bit adder. A run of num_samples sums is streamed out over a
// valid/ready handshake and compacted into a MISR signature.
// Optional macro LFSR_ADD_BIST_SPLIT_ADD_EN splits the adder into two
// registered halves, adding one cycle of latency. Results are unchanged.
module lfsr_add_bist #(
  parameter int              WIDTH = 12,
  parameter logic [WIDTH-1:0] TAPS  = 12'h829,
  parameter int              CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic             cin,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             sample_ready,
  output logic             sample_valid,
  output logic [WIDTH-1:0] sample_sum,
  output logic             sample_cout,
  output logic [CNT_W-1:0] sample_idx,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr_a, lfsr_b;
  logic             cin_r;
  logic [CNT_W-1:0] n_r, cnt, cnt_nxt;

  logic start_ok, xfer, out_free;
  logic issue, load_out, pipe_empty;
  logic [WIDTH-1:0] out_sum_d;
  logic             out_cout_d;
  logic [CNT_W-1:0] out_idx_d;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign xfer     = sample_valid && sample_ready;
  assign out_free = !sample_valid || sample_ready;
  assign cnt_nxt  = cnt + CNT_W'(1);
  assign busy     = (state == RUN) || (state == DRAIN);

`ifdef LFSR_ADD_BIST_SPLIT_ADD_EN
  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;

  logic             v1;
  logic [LO_W-1:0]  lo1;
  logic             c1;
  logic [HI_W-1:0]  ahi1, bhi1;
  logic [CNT_W-1:0] idx1;
  logic [LO_W:0]    lo_sum;
  logic [HI_W:0]    hi_sum;

  // Low half adds in stage 1; the high half completes when moving to the output register
  always_comb begin
    issue      = (state == RUN) && (!v1 || out_free);
    load_out   = v1 && out_free;
    lo_sum     = {1'b0, lfsr_a[LO_W-1:0]} + {1'b0, lfsr_b[LO_W-1:0]} + {{LO_W{1'b0}}, cin_r};
    hi_sum     = {1'b0, ahi1} + {1'b0, bhi1} + {{HI_W{1'b0}}, c1};
    out_sum_d  = {hi_sum[HI_W-1:0], lo1};
    out_cout_d = hi_sum[HI_W];
    out_idx_d  = idx1;
    pipe_empty = !v1;
  end

  // Stage-1 register: fills on issue, empties when handed to the output register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1   <= 1'b0;
      lo1  <= '0;
      c1   <= 1'b0;
      ahi1 <= '0;
      bhi1 <= '0;
      idx1 <= '0;
    end else if (issue) begin
      v1   <= 1'b1;
      lo1  <= lo_sum[LO_W-1:0];
      c1   <= lo_sum[LO_W];
      ahi1 <= lfsr_a[WIDTH-1:LO_W];
      bhi1 <= lfsr_b[WIDTH-1:LO_W];
      idx1 <= cnt;
    end else if (load_out) begin
      v1   <= 1'b0;
    end
  end
`else
  logic [WIDTH:0] full_sum;

  // Single-stage adder feeding the output register directly
  always_comb begin
    issue      = (state == RUN) && out_free;
    load_out   = issue;
    full_sum   = {1'b0, lfsr_a} + {1'b0, lfsr_b} + {{WIDTH{1'b0}}, cin_r};
    out_sum_d  = full_sum[WIDTH-1:0];
    out_cout_d = full_sum[WIDTH];
    out_idx_d  = cnt;
    pipe_empty = 1'b1;
  end
`endif

  // Run control FSM, LFSRs, output register and MISR
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      lfsr_a       <= WIDTH'(1);
      lfsr_b       <= WIDTH'(1);
      cin_r        <= 1'b0;
      n_r          <= '0;
      cnt          <= '0;
      sample_valid <= 1'b0;
      sample_sum   <= '0;
      sample_cout  <= 1'b0;
      sample_idx   <= '0;
      done         <= 1'b0;
      signature    <= '0;
    end else if (start_ok) begin
      lfsr_a    <= (seed_a == '0) ? WIDTH'(1) : seed_a;
      lfsr_b    <= (seed_b == '0) ? WIDTH'(1) : seed_b;
      cin_r     <= cin;
      n_r       <= num_samples;
      cnt       <= '0;
      signature <= '0;
      done      <= (num_samples == '0);
      state     <= (num_samples == '0) ? DONE : RUN;
    end else begin
      if (issue) begin
        lfsr_a <= step(lfsr_a);
        lfsr_b <= step(lfsr_b);
        cnt    <= cnt_nxt;
        if (cnt_nxt == n_r) state <= DRAIN;
      end
      if (load_out) begin
        sample_valid <= 1'b1;
        sample_sum   <= out_sum_d;
        sample_cout  <= out_cout_d;
        sample_idx   <= out_idx_d;
      end else if (xfer) begin
        sample_valid <= 1'b0;
      end
      if (xfer) signature <= step(signature) ^ sample_sum;
      if ((state == DRAIN) && xfer && pipe_empty) begin
        state <= DONE;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_add_bist.sv
// Directed bench for lfsr_add_bist (default parameters WIDTH=12, TAPS=0x829).
module tb_lfsr_add_bist;

  logic        clk = 1'b0;
  logic        resetn, start, cin, sample_ready;
  logic [11:0] seed_a, seed_b;
  logic [15:0] num_samples;
  logic        sample_valid, sample_cout, busy, done;
  logic [11:0] sample_sum, signature;
  logic [15:0] sample_idx;

  int total = 0;
  int bad   = 0;

`ifdef LFSR_ADD_BIST_SPLIT_ADD_EN
  localparam int LAT = 2;  // edges after the start edge until valid is visible
`else
  localparam int LAT = 1;
`endif

  lfsr_add_bist #(.WIDTH(12), .TAPS(12'h829), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .seed_a(seed_a), .seed_b(seed_b),
    .cin(cin), .num_samples(num_samples), .sample_ready(sample_ready),
    .sample_valid(sample_valid), .sample_sum(sample_sum), .sample_cout(sample_cout),
    .sample_idx(sample_idx), .busy(busy), .done(done), .signature(signature)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] mstep(input logic [11:0] s);
    return (s >> 1) ^ (s[0] ? 12'h829 : 12'h000);
  endfunction

  task automatic run_check(input logic [11:0] sa, input logic [11:0] sb, input logic c,
                           input logic [15:0] n, input int bp_at, input int bp_len,
                           output logic [11:0] sig_out);
    logic [11:0] ea, eb, esig;
    logic [12:0] esum;
    int cycles, xfers, last_x, bp_cnt, limit;
    bit first;
    @(negedge clk);
    seed_a = sa; seed_b = sb; cin = c; num_samples = n; start = 1'b1; sample_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ea = (sa == 12'h000) ? 12'h001 : sa;
    eb = (sb == 12'h000) ? 12'h001 : sb;
    esig = 12'h000;
    esum = {1'b0, ea} + {1'b0, eb} + {12'h000, c};
    cycles = 0; xfers = 0; last_x = 0; bp_cnt = 0; first = 1'b1;
    limit = 4 * int'(n) + bp_len + 20;
    while (!done && cycles < limit) begin
      if (sample_valid) begin
        if (first) begin
          check("first_valid_latency", cycles, LAT);
          first = 1'b0;
        end
        if (int'(sample_idx) == bp_at && bp_cnt < bp_len) begin
          sample_ready = 1'b0;
          bp_cnt++;
          check("stall_idx", sample_idx, bp_at);
          check("stall_sum", sample_sum, esum[11:0]);
        end else begin
          sample_ready = 1'b1;
          check("word_idx", sample_idx, xfers);
          check("word_sum", sample_sum, esum[11:0]);
          check("word_cout", sample_cout, esum[12]);
          esig = mstep(esig) ^ esum[11:0];
          xfers++;
          last_x = cycles;
          ea = mstep(ea);
          eb = mstep(eb);
          esum = {1'b0, ea} + {1'b0, eb} + {12'h000, c};
        end
      end
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    sample_ready = 1'b1;
    check("done_set", done, 1);
    check("xfer_count", xfers, n);
    if (n != 16'd0) check("done_delay", cycles - last_x, 1);
    check("final_sig", signature, esig);
    check("busy_low_at_done", busy, 0);
    check("valid_low_at_done", sample_valid, 0);
    sig_out = signature;
  endtask

  initial begin
    logic [11:0] sig;
    int g;
    resetn = 1'b0; start = 1'b0; cin = 1'b0; seed_a = '0; seed_b = '0;
    num_samples = '0; sample_ready = 1'b1;
    #12;
    check("rst_valid", sample_valid, 0);
    check("rst_sum", sample_sum, 0);
    check("rst_cout", sample_cout, 0);
    check("rst_idx", sample_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sig", signature, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Example run: words 0x00A, 0x056 (cout), 0x87C (cout); signature 0x07C
    run_check(12'h001, 12'h009, 1'b0, 16'd3, -1, 0, sig);
    check("example_sig", sig, 12'h07C);

    // Zero-length run
    run_check(12'h005, 12'h006, 1'b0, 16'd0, -1, 0, sig);
    check("n0_sig", sig, 12'h000);

    // Zero seeds replaced by 1: 1+1+1 = 3
    run_check(12'h000, 12'h000, 1'b1, 16'd1, -1, 0, sig);
    check("zero_seed_sig", sig, 12'h003);

    // Backpressure at idx 2 for 4 cycles, then same run with ready high
    run_check(12'h001, 12'h009, 1'b0, 16'd5, 2, 4, sig);
    check("bp_sig", sig, 12'h84D);
    run_check(12'h001, 12'h009, 1'b0, 16'd5, -1, 0, sig);
    check("nobp_sig", sig, 12'h84D);

    // Reset mid-run at idx 3 of 10
    @(negedge clk);
    seed_a = 12'h001; seed_b = 12'h009; cin = 1'b0; num_samples = 16'd10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!(sample_valid && sample_idx == 16'd3) && g < 50) begin
      @(posedge clk);
      @(negedge clk);
      g++;
    end
    check("midrun_reached_idx3", sample_idx, 3);
    #2 resetn = 1'b0;
    #1;
    check("midrst_valid", sample_valid, 0);
    check("midrst_sum", sample_sum, 0);
    check("midrst_cout", sample_cout, 0);
    check("midrst_idx", sample_idx, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sig", signature, 0);
    @(negedge clk);
    resetn = 1'b1;
    run_check(12'h123, 12'h0F0, 1'b0, 16'd2, -1, 0, sig);

    // Long run for cross-build comparison of stream and signature
    run_check(12'h001, 12'h009, 1'b0, 16'd100, -1, 0, sig);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_add_bist.md
# lfsr_add_bist

Parametrised self-running stimulus-and-check engine for the adder datapath. Two seeded Galois LFSRs of WIDTH bits feed a WIDTH-bit adder. A fixed-length run of sums is streamed out under a valid/ready handshake and compacted into a MISR signature. The bench compares one signature word per run in place of a per-cycle file comparison. It sits between the LFSR and adder blocks and the result logger.

## Interface
Parameters:
- WIDTH, 12, LFSR, adder and signature width.
- TAPS, 12'h829, Galois feedback mask, right-shift form. Default is x^12+x^6+x^4+x+1.
- CNT_W, 16, width of the sample counter and of num_samples.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle run request.
- seed_a  in  WIDTH  seed for LFSR A, sampled on accepted start.
- seed_b  in  WIDTH  seed for LFSR B, sampled on accepted start.
- cin  in  1  adder carry-in, latched on accepted start.
- num_samples  in  CNT_W  run length, latched on accepted start.
- sample_ready  in  1  downstream can accept.
- sample_valid  out  1  output word valid.
- sample_sum  out  WIDTH  a+b+cin, low WIDTH bits.
- sample_cout  out  1  carry-out of that sum.
- sample_idx  out  CNT_W  0-based index of the word.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next accepted start.
- signature  out  WIDTH  MISR state.

## Operation
- LFSR step function: step(s) = (s >> 1) ^ (s[0] ? TAPS : 0).
- A zero seed is replaced by 1, so the LFSR never locks up.
- FSM states: IDLE, RUN, DRAIN, DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE.
  - Next cycle: lfsr_a and lfsr_b load their (fixed) seeds; cin and num_samples are latched; issue counter = 0; signature = 0; done = 0.
  - State becomes RUN, or DONE directly if num_samples == 0.
  - start in RUN or DRAIN is ignored.
- Issue rule, in RUN:
  - Condition: the output register is empty, or it is being consumed (sample_valid && sample_ready).
  - Action: the output register loads {sample_cout, sample_sum} = lfsr_a + lfsr_b + cin (WIDTH+1-bit result) and sample_idx = counter; sample_valid becomes 1.
  - Both LFSRs step and the counter increments.
  - When the counter reaches num_samples, go to DRAIN.
- Stall: if sample_valid && !sample_ready, everything holds: LFSRs, counter, output register and signature.
- Signature: on each accepted transfer (valid && ready), signature <= step(signature) ^ sample_sum.
- DRAIN: once the last word is accepted and the pipeline is empty, go to DONE. sample_valid drops unless refilled.
- busy = 1 in RUN and DRAIN.
- DONE holds signature and done = 1 until the next accepted start.

## Timing
- Reset values of all outputs: every output is 0. FSM is in IDLE, LFSRs = 1, counter = 0.
- Reset mid-run aborts immediately. No partial done is produced.
- Latency: start accepted at edge k. RUN from k+1. First sample_valid at k+2, carrying seed_a + seed_b + cin.
- With ready held high, one word per cycle. The last word (idx N-1) is valid at edge k+1+N.
- done rises the cycle after the last accepted transfer.
- The signature is final in the same cycle that done rises.
- Counter wrap: num_samples is at most 2^CNT_W − 1, so the counter never wraps within a run.

## Configuration
- Macro: LFSR_ADD_BIST_SPLIT_ADD_EN.
- Defined:
  - The adder is split at bit WIDTH/2.
  - The low half and its carry are registered in one stage; the high half is added in a second stage.
  - Total latency grows by one cycle: first valid at k+3.
  - The handshake stall propagates through both stages; no bubble is inserted at full throughput.
  - Sums, ordering and signature are identical to the undefined case.
- Undefined: single-stage adder, with timing as above.

## Test plan
- Defaults, seed_a = 1, seed_b = 9, cin = 0, N = 3, ready = 1:
  - Words: (idx 0, sum 10), (idx 1, 0x829 + 0x82D = 0x056, cout 1), (idx 2, 0xC3D + step(0x82D)).
  - done rises one cycle after idx 2.
- N = 0: start → done = 1 after one cycle, sample_valid never asserts, signature = 0.
- seed_a = 0: the first word uses LFSR A = 1.
  - With seed_b = 0 and cin = 1, the first sum is 3.
- Backpressure: N = 5, ready low for 4 cycles at idx 2.
  - sample_sum and sample_idx hold stable.
  - Signature matches the ready-high run.
  - Still exactly 5 transfers.
- Reset mid-run: resetn low at idx 3 of N = 10.
  - All outputs 0 asynchronously.
  - A new start produces idx 0 from the new seeds.
- Build with and without LFSR_ADD_BIST_SPLIT_ADD_EN, N = 100, seeds 1 and 9:
  - Identical sample streams and final signature.
  - First valid at k+2 without the macro, k+3 with it.
